// File: rtl/rom_load_pkg.sv
// Shared types and width helpers for the cartridge ROM load bridge.
package rom_load_pkg;

  localparam int unsigned CSUM_W = 16;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } fsm_state_t;

  function automatic int unsigned bank_w(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned ofs_w(input int unsigned addr_w, input int unsigned num_banks);
    return addr_w - $clog2(num_banks);
  endfunction

  function automatic int unsigned waddr_w(input int unsigned addr_w, input int unsigned num_banks,
                                          input int unsigned pack);
    return addr_w - $clog2(num_banks) - $clog2(pack);
  endfunction

  // Lane index is kept at least one bit wide so PACK=1 still yields a legal vector.
  function automatic int unsigned lane_w(input int unsigned pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/rom_load_bridge_strobe_edge.sv
// Registered rising-edge detector; RST_VAL=1 masks a strobe already high at reset release.
module strobe_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic accept_c
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= RST_VAL;
    else        prev_q <= strobe;
  end

  assign accept_c = strobe & ~prev_q;

endmodule

// File: rtl/rom_load_bridge.sv
// CPU byte-write conduit to banked wide-word cartridge memories: direct writes or
// auto-incrementing packed stream loads with checksum, byte count and overflow.
module rom_load_bridge
  import rom_load_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned PACK      = 2,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned MEM_W    = PACK * DATA_W,
  localparam int unsigned BANK_W   = bank_w(NUM_BANKS),
  localparam int unsigned OFS_W    = ofs_w(ADDR_W, NUM_BANKS),
  localparam int unsigned WADDR_W  = waddr_w(ADDR_W, NUM_BANKS, PACK),
  localparam int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [DATA_W-1:0]    to_game_rom,
  input  logic                 write_rom,
  input  logic [ADDR_W-1:0]    rom_addr,
  input  logic                 stream_mode,
  input  logic                 load_clr,
  input  logic                 flush,
  output logic [NUM_BANKS-1:0] mem_we,
  output logic [WADDR_W-1:0]   mem_addr,
  output logic [MEM_W-1:0]     mem_wdata,
  output logic [PACK-1:0]      mem_be,
  output logic [CSUM_W-1:0]    checksum,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned LSB_W  = $clog2(PACK);
  localparam int unsigned LANE_W = lane_w(PACK);

  logic accept_c;

  strobe_edge #(.RST_VAL(1'b1)) u_strobe_edge (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .strobe   (write_rom),
    .accept_c (accept_c)
  );

  fsm_state_t           state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d, cur_ptr;
  logic [MEM_W-1:0]     buf_q, buf_d, word_buf;
  logic [PACK-1:0]      fill_q, fill_d, word_fill;
  logic [LANE_W-1:0]    lane;
  logic [PACK-1:0]      lane_oh;
  logic [OFS_W-1:0]     ofs_nx;
  logic [WADDR_W-1:0]   wr_waddr;
  logic [NUM_BANKS-1:0] wr_bank;
  logic                 stream_c, do_write;

  logic [NUM_BANKS-1:0] we_d;
  logic [WADDR_W-1:0]   addr_d;
  logic [MEM_W-1:0]     wdata_d;
  logic [PACK-1:0]      be_d;
  logic [CSUM_W-1:0]    csum_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ovf_d;

  // Once a stream is running the latched pointer owns addressing and mode.
  assign stream_c = (state_q == RUN) || stream_mode;
  assign cur_ptr  = (state_q == RUN) ? ptr_q : rom_addr;
  assign lane     = (PACK > 1) ? cur_ptr[LANE_W-1:0] : '0;
  assign lane_oh  = PACK'(1) << lane;
  assign ofs_nx   = cur_ptr[OFS_W-1:0] + OFS_W'(1);
  assign wr_waddr = WADDR_W'(cur_ptr[OFS_W-1:0] >> LSB_W);
  assign wr_bank  = NUM_BANKS'(1) << cur_ptr[ADDR_W-1 -: BANK_W];
  assign busy     = |fill_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    we_d      = '0;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    be_d      = mem_be;
    csum_d    = checksum;
    cnt_d     = byte_count;
    ovf_d     = overflow;
    word_buf  = buf_q;
    word_fill = fill_q;
    do_write  = 1'b0;

    if (load_clr) begin
      state_d = ARM;
      buf_d   = '0;
      fill_d  = '0;
      csum_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept_c && !stream_c) begin
      we_d    = wr_bank;
      addr_d  = wr_waddr;
      wdata_d = {PACK{to_game_rom}};
      be_d    = lane_oh;
      csum_d  = checksum + CSUM_W'(to_game_rom);
      cnt_d   = (&byte_count) ? byte_count : byte_count + CNT_W'(1);
    end else begin
      if (accept_c && !overflow) begin
        for (int i = 0; i < int'(PACK); i++) begin
          if (lane == LANE_W'(i)) word_buf[i*DATA_W +: DATA_W] = to_game_rom;
        end
        word_fill = word_fill | lane_oh;
        ptr_d     = {cur_ptr[ADDR_W-1 -: BANK_W], ofs_nx};
        state_d   = RUN;
        csum_d    = checksum + CSUM_W'(to_game_rom);
        cnt_d     = (&byte_count) ? byte_count : byte_count + CNT_W'(1);
        if (lane == LANE_W'(PACK - 1)) do_write = 1'b1;
        // Offset wrap means the bank is exhausted: commit and lock out further bytes.
        if (ofs_nx == '0) begin
          ovf_d    = 1'b1;
          do_write = 1'b1;
        end
      end
      if (flush && (word_fill != '0)) do_write = 1'b1;
      if (do_write) begin
        we_d    = wr_bank;
        addr_d  = wr_waddr;
        wdata_d = word_buf;
        be_d    = word_fill;
        buf_d   = '0;
        fill_d  = '0;
      end else begin
        buf_d   = word_buf;
        fill_d  = word_fill;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ARM;
      ptr_q      <= '0;
      buf_q      <= '0;
      fill_q     <= '0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      checksum   <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      mem_be     <= be_d;
      checksum   <= csum_d;
      byte_count <= cnt_d;
      overflow   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rom_load_bridge.sv
// Self-checking bench for rom_load_bridge: directed scenarios plus randomized traffic
// against a byte/offset-level reference model.
module tb_rom_load_bridge;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned PACK      = 2;
  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned SPAN      = 1 << (ADDR_W - 1);
  localparam int unsigned CNT_MAX   = (1 << (ADDR_W + 1)) - 1;

  logic                 clk_clk = 1'b0;
  logic                 reset_reset_n;
  logic [DATA_W-1:0]    to_game_rom;
  logic                 write_rom;
  logic [ADDR_W-1:0]    rom_addr;
  logic                 stream_mode;
  logic                 load_clr;
  logic                 flush;
  logic [NUM_BANKS-1:0] mem_we;
  logic [13:0]          mem_addr;
  logic [15:0]          mem_wdata;
  logic [PACK-1:0]      mem_be;
  logic [15:0]          checksum;
  logic [16:0]          byte_count;
  logic                 busy;
  logic                 overflow;

  always #5 clk_clk = ~clk_clk;

  rom_load_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PACK(PACK), .NUM_BANKS(NUM_BANKS)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .to_game_rom(to_game_rom),
    .write_rom(write_rom), .rom_addr(rom_addr), .stream_mode(stream_mode),
    .load_clr(load_clr), .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .checksum(checksum),
    .byte_count(byte_count), .busy(busy), .overflow(overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: integer bank/offset bookkeeping
  bit m_prev, m_run, m_ovf;
  int m_bank, m_ofs, m_waddr, m_mask, m_csum, m_cnt;
  int m_pend [PACK];
  int e_we, e_addr, e_data, e_be;

  // Outputs captured on the cycle after the rising strobe
  int r_we, r_addr, r_data, r_be, r_csum, r_cnt, r_busy, r_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_run = 1'b0; m_ovf = 1'b0;
    m_bank = 0; m_ofs = 0; m_waddr = 0; m_mask = 0; m_csum = 0; m_cnt = 0;
    for (int l = 0; l < int'(PACK); l++) m_pend[l] = 0;
  endtask

  task automatic model_add_byte();
    m_csum = (m_csum + int'(to_game_rom)) % 65536;
    if (m_cnt < int'(CNT_MAX)) m_cnt++;
  endtask

  task automatic model_step();
    bit acc, wr;
    int lane, a;
    a    = int'(rom_addr);
    acc  = write_rom && !m_prev;
    m_prev = write_rom;
    e_we = 0;
    wr   = 1'b0;
    if (load_clr) begin
      m_run = 1'b0; m_ovf = 1'b0; m_mask = 0; m_csum = 0; m_cnt = 0;
    end else if (acc && !(m_run || stream_mode)) begin
      lane   = a % int'(PACK);
      e_we   = 1 << (a / int'(SPAN));
      e_addr = (a % int'(SPAN)) / int'(PACK);
      e_be   = 1 << lane;
      e_data = 0;
      for (int l = 0; l < int'(PACK); l++) e_data = e_data | (int'(to_game_rom) << (DATA_W * l));
      model_add_byte();
    end else begin
      if (acc && !m_ovf) begin
        if (!m_run) begin
          m_bank = a / int'(SPAN);
          m_ofs  = a % int'(SPAN);
          m_run  = 1'b1;
        end
        lane          = m_ofs % int'(PACK);
        m_waddr       = m_ofs / int'(PACK);
        m_pend[lane]  = int'(to_game_rom);
        m_mask        = m_mask | (1 << lane);
        m_ofs++;
        model_add_byte();
        if (lane == int'(PACK) - 1) wr = 1'b1;
        if (m_ofs == int'(SPAN)) begin m_ovf = 1'b1; wr = 1'b1; end
      end
      if (flush && m_mask != 0) wr = 1'b1;
      if (wr) begin
        e_we   = 1 << m_bank;
        e_addr = m_waddr;
        e_be   = m_mask;
        e_data = 0;
        for (int l = 0; l < int'(PACK); l++)
          if (m_mask[l]) e_data = e_data | (m_pend[l] << (DATA_W * l));
        m_mask = 0;
      end
    end
  endtask

  // One clock: predict from the inputs in place, then compare just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk_clk);
    #1;
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we != 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
      chk("mem_be", 32'(mem_be), 32'(e_be));
    end
    chk("checksum", 32'(checksum), 32'(m_csum));
    chk("byte_count", 32'(byte_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_mask != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic send(input int addr, input int data, input bit fl);
    rom_addr    = 16'(addr);
    to_game_rom = 8'(data);
    write_rom   = 1'b1;
    flush       = fl;
    tick();
    r_we = int'(mem_we); r_addr = int'(mem_addr); r_data = int'(mem_wdata); r_be = int'(mem_be);
    r_csum = int'(checksum); r_cnt = int'(byte_count); r_busy = int'(busy); r_ovf = int'(overflow);
    write_rom = 1'b0;
    flush     = 1'b0;
    tick();
  endtask

  task automatic clear_pulse(input bit with_edge);
    load_clr  = 1'b1;
    write_rom = with_edge;
    tick();
    load_clr  = 1'b0;
    write_rom = 1'b0;
    tick();
  endtask

  initial begin
    reset_reset_n = 1'b0;
    write_rom = 1'b1;
    to_game_rom = '0; rom_addr = '0; stream_mode = 1'b0; load_clr = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_checksum", 32'(checksum), 32'h0);
    chk("rst_byte_count", 32'(byte_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // Strobe already high at reset release must not write
    reset_reset_n = 1'b1;
    rom_addr = 16'h0004; to_game_rom = 8'h77;
    tick(); tick();
    chk("hi_at_release_cnt", 32'(byte_count), 32'h0);
    write_rom = 1'b0;
    tick();

    // Direct byte write into bank 1
    send(16'h8003, 8'hA5, 1'b0);
    chk("direct_we", 32'(r_we), 32'h2);
    chk("direct_addr", 32'(r_addr), 32'h1);
    chk("direct_be", 32'(r_be), 32'h2);
    chk("direct_wdata", 32'(r_data), 32'hA5A5);
    chk("direct_csum", 32'(r_csum), 32'h00A5);
    clear_pulse(1'b0);

    // Streamed, two full words
    stream_mode = 1'b1;
    send(16'h0000, 8'h11, 1'b0);
    chk("stream_busy1", 32'(r_busy), 32'h1);
    send(16'h1234, 8'h22, 1'b0);
    chk("stream_w0", 32'({r_we, r_addr, r_data, r_be}), 32'({32'h1, 32'h0, 32'h2211, 32'h3}));
    send(16'h5555, 8'h33, 1'b0);
    send(16'h0000, 8'h44, 1'b0);
    chk("stream_w1_we", 32'(r_we), 32'h1);
    chk("stream_w1_addr", 32'(r_addr), 32'h1);
    chk("stream_w1_data", 32'(r_data), 32'h4433);
    chk("stream_w1_be", 32'(r_be), 32'h3);
    chk("stream_cnt", 32'(r_cnt), 32'h4);
    chk("stream_csum", 32'(r_csum), 32'h00AA);
    clear_pulse(1'b0);

    // Three bytes then an explicit flush of the odd byte
    send(16'h0000, 8'h11, 1'b0);
    send(16'h0000, 8'h22, 1'b0);
    send(16'h0000, 8'h33, 1'b0);
    chk("flush_busy_before", 32'(busy), 32'h1);
    flush = 1'b1;
    tick();
    chk("flush_we", 32'(mem_we), 32'h1);
    chk("flush_addr", 32'(mem_addr), 32'h1);
    chk("flush_be", 32'(mem_be), 32'h1);
    chk("flush_data", 32'(mem_wdata), 32'h0033);
    chk("flush_busy", 32'(busy), 32'h0);
    flush = 1'b0;
    tick();
    clear_pulse(1'b0);

    // Run off the end of bank 0
    send(16'h7FFE, 8'h01, 1'b0);
    send(16'h0000, 8'h02, 1'b0);
    chk("ovf_addr", 32'(r_addr), 32'h3FFF);
    chk("ovf_be", 32'(r_be), 32'h3);
    chk("ovf_flag", 32'(r_ovf), 32'h1);
    send(16'h0000, 8'h03, 1'b0);
    chk("ovf_drop_we", 32'(r_we), 32'h0);
    chk("ovf_drop_cnt", 32'(r_cnt), 32'h2);

    // Clear coincident with an edge drops the byte; next edge re-latches the pointer
    clear_pulse(1'b1);
    chk("clr_edge_cnt", 32'(byte_count), 32'h0);
    chk("clr_edge_csum", 32'(checksum), 32'h0);
    send(16'h8010, 8'h55, 1'b0);
    send(16'h0000, 8'h66, 1'b0);
    chk("relatch_we", 32'(r_we), 32'h2);
    chk("relatch_addr", 32'(r_addr), 32'h8);
    chk("relatch_data", 32'(r_data), 32'h6655);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op, a;
      op = int'($urandom_range(0, 19));
      if (op == 0) begin
        clear_pulse(1'($urandom_range(0, 1)));
      end else if (op == 1) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) stream_mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0)
          a = (int'($urandom_range(0, 1)) << 15) | (32'h7FF0 + int'($urandom_range(0, 15)));
        else
          a = int'($urandom_range(0, 65535));
        send(a, int'($urandom_range(0, 255)), 1'($urandom_range(0, 4) == 0));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_load_bridge.md
# rom_load_bridge

Parametrised successor to the single-byte game-ROM write conduit. Receives CPU-driven data/address/strobe from the SoC PIO conduit and writes a multi-bank, wider-word cartridge memory (PRG/CHR). Supports direct addressed byte writes and auto-incrementing streamed loads with lane packing, a running checksum, a byte counter and overflow detection. Sits between the SoC conduit and the on-chip cartridge ROM RAMs.

## Interface
- DATA_W, 8: width of one CPU write (byte).
- ADDR_W, 16: CPU-side byte address width.
- PACK, 2: DATA_W lanes per memory word (1, 2 or 4); MEM_W = PACK*DATA_W.
- NUM_BANKS, 2: number of target memories (power of two, ≥2).
- BANK_W = log2(NUM_BANKS); OFS_W = ADDR_W-BANK_W; WADDR_W = OFS_W-log2(PACK).

- clk_clk  in  1  system clock, all logic rising-edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- to_game_rom  in  DATA_W  write data from CPU.
- write_rom  in  1  level strobe from CPU; each rising edge is one write.
- rom_addr  in  ADDR_W  byte address; top BANK_W bits = bank, rest = byte offset.
- stream_mode  in  1  0 = direct, 1 = streamed (auto-increment).
- load_clr  in  1  one-cycle pulse: clear checksum, count, overflow, partial word; re-arm stream pointer.
- flush  in  1  one-cycle pulse: write pending partial word.
- mem_we  out  NUM_BANKS  one-hot write enable, one cycle.
- mem_addr  out  WADDR_W  word address.
- mem_wdata  out  MEM_W  write data, lane 0 = bits [DATA_W-1:0].
- mem_be  out  PACK  lane byte enables.
- checksum  out  16  sum of accepted bytes mod 2^16.
- byte_count  out  ADDR_W+1  accepted bytes since clear.
- busy  out  1  partial stream word pending.
- overflow  out  1  sticky: stream pointer passed end of bank.

## Operation
- Edge detect: write_rom registered; accept = write_rom & ~prev. prev resets to 1 (a high strobe at reset release is not a write).
- Accepted byte: checksum += zero-extended data; byte_count += 1 (saturates at all-ones).
- Direct mode: bank/offset from rom_addr; write immediately, lane = offset[log2(PACK)-1:0], mem_be one-hot on that lane, data replicated on all lanes.
- Stream mode: first accept after reset/load_clr latches pointer = rom_addr (state ARM→RUN); later accepts ignore rom_addr. Byte goes into lane pointer[lane bits]; pointer += 1. When last lane fills, write the word, mem_be = lanes filled since the last write.
- flush in RUN with pending lanes: write them, mem_be = filled lanes, unfilled lanes 0; flush with none pending: no-op.
- Pointer reaching end of bank (offset wraps to 0): overflow set, pending word written, further stream bytes dropped (not counted, not summed) until load_clr.
- stream_mode change is honoured only in IDLE/ARM; in RUN it is ignored until load_clr.
- FSM: ARM (stream, pointer unset) → RUN on accept; RUN → ARM on load_clr; any → ARM on reset. Direct writes bypass the FSM.

## Timing
- Reset outputs: mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, checksum 0, byte_count 0, busy 0, overflow 0; FSM ARM.
- Latency: write_rom rising at sample cycle n → mem_we pulse at n+1 (direct, or final lane) for exactly one cycle. checksum/byte_count update at n+1.
- Minimum strobe spacing 2 cycles (high,low); every edge accepted, no backpressure.
- load_clr and accept same cycle: clear wins, byte dropped. flush and accept same cycle: accept first, then flush in the same write (one mem_we pulse).
- busy high from first partial-lane accept until the write cycle.

## Structure
- rom_load_pkg: fsm_state_t (ARM, RUN), width helpers (BANK_W, OFS_W, WADDR_W, lane-index width), checksum width constant 16.
- Sub-module strobe_edge: registered rising-edge detector with parameterised reset value of prev.

## Test plan
- Direct, PACK=2: addr 0x8003 data 0xA5 → mem_we=2'b10, mem_addr 0x0001, mem_be 2'b10, mem_wdata 0xA5A5, checksum 0x00A5, one cycle after edge.
- Stream from 0x0000, bytes 0x11,0x22,0x33,0x44 → two writes bank0 addr 0/1, data 0x2211/0x4433, be 2'b11; byte_count 4, checksum 0x00AA.
- Stream 3 bytes then flush → second write mem_be 2'b01, data 0x0033; busy drops same cycle.
- Stream from 0x7FFE (end of bank0), 3 bytes → 0x7FFE–7FFF written, overflow=1, third byte dropped, byte_count 2.
- load_clr coincident with edge → no write, checksum/count 0, state ARM; next edge latches new rom_addr.
- write_rom high at reset release → no write until low-then-high.
